// File: rtl/regfile_access_ctrl_if.sv
// Handshake bundle between execute/writeback logic and regfile_access_ctrl.
// master = upstream requester, slave = the controller.
interface regfile_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_sa;
  logic [ADDR_W-1:0] rd_sb;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output rd_valid, rd_sa, rd_sb, op_ready, wb_valid, wb_addr, wb_data,
    input  rd_ready, op_valid, op_a, op_b, wb_ready
  );

  modport slave (
    input  rd_valid, rd_sa, rd_sb, op_ready, wb_valid, wb_addr, wb_data,
    output rd_ready, op_valid, op_a, op_b, wb_ready
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Operand-read sequencer and writeback queue in front of register_file.
// Define REGFILE_BYPASS_EN to forward queued writes into operands instead of stalling reads.
module regfile_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int WQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_access_ctrl_if.slave bus,
  output logic [ADDR_W-1:0]    AA,
  output logic [ADDR_W-1:0]    BA,
  input  logic [DATA_W-1:0]    A,
  input  logic [DATA_W-1:0]    B,
  output logic [ADDR_W-1:0]    DA,
  output logic [DATA_W-1:0]    D,
  output logic                 RW
);
  localparam int CNT_W = $clog2(WQ_DEPTH + 1);
  localparam int IDX_W = $clog2(WQ_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WQ_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // ---------------- write queue (entry 0 is the head) ----------------
  logic [ADDR_W-1:0] q_addr [WQ_DEPTH];
  logic [DATA_W-1:0] q_data [WQ_DEPTH];
  logic [ADDR_W-1:0] n_addr [WQ_DEPTH];
  logic [DATA_W-1:0] n_data [WQ_DEPTH];
  logic [WQ_DEPTH-1:0] q_vld;
  logic [CNT_W-1:0]  q_cnt;
  logic [CNT_W-1:0]  wr_idx;
  logic              q_full;
  logic              push;
  logic              pop;

  assign q_full       = (q_cnt == FULL_CNT);
  assign bus.wb_ready = !q_full;
  assign push         = bus.wb_valid && !q_full;
  assign pop          = (q_cnt != '0);

  always_comb begin
    q_vld = '0;
    for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
      q_vld[IDX_W'(i)] = (CNT_W'(i) < q_cnt);
    end
  end

  // Shift on pop, then place the new entry behind the surviving ones.
  always_comb begin
    wr_idx = pop ? (q_cnt - 1'b1) : q_cnt;
    for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
      n_addr[IDX_W'(i)] = q_addr[IDX_W'(i)];
      n_data[IDX_W'(i)] = q_data[IDX_W'(i)];
      if (pop && (i < WQ_DEPTH - 1)) begin
        n_addr[IDX_W'(i)] = q_addr[IDX_W'(i + 1)];
        n_data[IDX_W'(i)] = q_data[IDX_W'(i + 1)];
      end
      if (push && (wr_idx == CNT_W'(i))) begin
        n_addr[IDX_W'(i)] = bus.wb_addr;
        n_data[IDX_W'(i)] = bus.wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    q_addr <= n_addr;
    q_data <= n_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_cnt <= '0;
    end else if (push && !pop) begin
      q_cnt <= q_cnt + 1'b1;
    end else if (!push && pop) begin
      q_cnt <= q_cnt - 1'b1;
    end
  end

  // Write port: head drains one entry per cycle; DA/D hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DA <= '0;
      D  <= '0;
      RW <= 1'b0;
    end else begin
      RW <= pop;
      if (pop) begin
        DA <= q_addr[0];
        D  <= q_data[0];
      end
    end
  end

  // ---------------- ordering against queued writes ----------------
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              rd_stall;

`ifdef REGFILE_BYPASS_EN
  // Ascending scan: a later (younger) match overrides an older one.
  always_comb begin
    fwd_a = A;
    fwd_b = B;
    for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
      if (q_vld[IDX_W'(i)] && (q_addr[IDX_W'(i)] == AA)) fwd_a = q_data[IDX_W'(i)];
      if (q_vld[IDX_W'(i)] && (q_addr[IDX_W'(i)] == BA)) fwd_b = q_data[IDX_W'(i)];
    end
  end

  assign rd_stall = 1'b0;
`else
  assign fwd_a = A;
  assign fwd_b = B;

  always_comb begin
    rd_stall = 1'b0;
    for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
      if (q_vld[IDX_W'(i)] &&
          ((q_addr[IDX_W'(i)] == bus.rd_sa) || (q_addr[IDX_W'(i)] == bus.rd_sb))) begin
        rd_stall = 1'b1;
      end
    end
  end
`endif

  // ---------------- read FSM ----------------
  logic [1:0]        state;
  logic              rd_ready_int;
  logic              accept;
  logic              op_valid_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;

  assign rd_ready_int = !rd_stall &&
                        ((state == S_IDLE) || ((state == S_HOLD) && bus.op_ready));
  assign accept       = bus.rd_valid && rd_ready_int;

  assign bus.rd_ready = rd_ready_int;
  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      AA         <= '0;
      BA         <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            AA    <= bus.rd_sa;
            BA    <= bus.rd_sb;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          op_a_q     <= fwd_a;
          op_b_q     <= fwd_b;
          op_valid_q <= 1'b1;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.op_ready) begin
            op_valid_q <= 1'b0;
            if (accept) begin
              AA    <= bus.rd_sa;
              BA    <= bus.rd_sb;
              state <= S_FETCH;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register_file (r[i]=i at power-up).
module tb_regfile_access_ctrl;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int WQ_DEPTH = 4;

`ifdef REGFILE_BYPASS_EN
  localparam int LAT_WR = 2;
  localparam int LAT_YW = 2;
`else
  localparam int LAT_WR = 3;
  localparam int LAT_YW = 4;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] AA, BA, DA;
  logic [DATA_W-1:0] A, B, D;
  logic              RW;
  logic [DATA_W-1:0] rf [32];

  int errors = 0;
  int checks = 0;

  regfile_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .AA(AA), .BA(BA), .A(A), .B(B), .DA(DA), .D(D), .RW(RW)
  );

  always #5 clk = ~clk;

  // register_file: combinational read, write on falling edge
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = i;
    forever begin
      @(negedge clk);
      if (RW === 1'b1) rf[DA] = D;
    end
  end
  assign A = rf[AA];
  assign B = rf[BA];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_op(output int lat, output bit got);
    bit acc;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      #1;
      acc = bus.rd_valid && bus.rd_ready;
      @(posedge clk);
      #1;
      lat++;
      bus.wb_valid = 1'b0;
      if (acc) bus.rd_valid = 1'b0;
      if (bus.op_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.rd_valid = 0; bus.rd_sa = '0; bus.rd_sb = '0; bus.op_ready = 0;
    bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;
    #2 rst = 1'b1;
    step(); step();
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %0b want 0", bus.op_valid); end
    checks++; if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0) begin errors++; $display("FAIL reset_ops: got %h/%h want 0/0", bus.op_a, bus.op_b); end
    checks++; if (AA !== 5'd0 || BA !== 5'd0) begin errors++; $display("FAIL reset_AA_BA: got %0d/%0d want 0/0", AA, BA); end
    checks++; if (DA !== 5'd0 || D !== 32'h0) begin errors++; $display("FAIL reset_DA_D: got %0d/%h want 0/0", DA, D); end
    checks++; if (RW !== 1'b0) begin errors++; $display("FAIL reset_RW: got %0b want 0", RW); end
    checks++; if (bus.rd_ready !== 1'b1 || bus.wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got rd=%0b wb=%0b want 1/1", bus.rd_ready, bus.wb_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_basic();
    bus.rd_valid = 1; bus.rd_sa = 5'd3; bus.rd_sb = 5'd7;
    step();
    bus.rd_valid = 0;
    checks++; if (AA !== 5'd3 || BA !== 5'd7) begin errors++; $display("FAIL read_addr: got %0d/%0d want 3/7", AA, BA); end
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL read_early_valid: got %0b want 0", bus.op_valid); end
    step();
    checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %0b want 1", bus.op_valid); end
    checks++; if (bus.op_a !== 32'd3 || bus.op_b !== 32'd7) begin errors++; $display("FAIL read_ops: got %h/%h want 3/7", bus.op_a, bus.op_b); end
    bus.op_ready = 1;
    step();
    bus.op_ready = 0;
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL read_release: got %0b want 0", bus.op_valid); end
  endtask

  task automatic test_write_then_read();
    int lat; bit got;
    bus.wb_valid = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    step();
    bus.wb_valid = 0;
    bus.rd_valid = 1; bus.rd_sa = 5'd5; bus.rd_sb = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL raw_rd_ready: got %0b want 1", bus.rd_ready); end
`else
    checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL raw_rd_ready: got %0b want 0", bus.rd_ready); end
`endif
    wait_op(lat, got);
    checks++; if (!got || lat != LAT_WR) begin errors++; $display("FAIL raw_latency: got %0d (valid=%0b) want %0d", lat, got, LAT_WR); end
    checks++; if (bus.op_a !== 32'hDEAD_BEEF || bus.op_b !== 32'd0) begin errors++; $display("FAIL raw_ops: got %h/%h want deadbeef/0", bus.op_a, bus.op_b); end
    bus.op_ready = 1;
    step();
    bus.op_ready = 0;
    step(); step();
  endtask

  task automatic test_youngest();
    int lat; bit got;
    bus.wb_valid = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'h11;
    step();
    bus.wb_data = 32'h22;
    bus.rd_valid = 1; bus.rd_sa = 5'd9; bus.rd_sb = 5'd9;
    wait_op(lat, got);
    checks++; if (!got || lat != LAT_YW) begin errors++; $display("FAIL young_latency: got %0d (valid=%0b) want %0d", lat, got, LAT_YW); end
    checks++; if (bus.op_a !== 32'h22 || bus.op_b !== 32'h22) begin errors++; $display("FAIL young_ops: got %h/%h want 22/22", bus.op_a, bus.op_b); end
    bus.op_ready = 1;
    step();
    bus.op_ready = 0;
    step(); step(); step();
    checks++; if (rf[9] !== 32'h22) begin errors++; $display("FAIL young_r9: got %h want 22", rf[9]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      bus.wb_valid = 1; bus.wb_addr = 5'(10 + i); bus.wb_data = 32'h100 + i;
      #1;
      checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL burst_wb_ready%0d: got %0b want 1", i, bus.wb_ready); end
      step();
      if (i > 0) begin
        checks++;
        if (RW !== 1'b1 || DA !== 5'(9 + i) || D !== 32'h100 + i - 1) begin
          errors++; $display("FAIL burst_pop%0d: got RW=%0b DA=%0d D=%h want 1/%0d/%h", i - 1, RW, DA, D, 9 + i, 32'h100 + i - 1);
        end
      end
    end
    bus.wb_valid = 0;
    step();
    checks++; if (RW !== 1'b1 || DA !== 5'd14 || D !== 32'h104) begin errors++; $display("FAIL burst_pop4: got RW=%0b DA=%0d D=%h want 1/14/104", RW, DA, D); end
    step();
    checks++; if (RW !== 1'b0 || DA !== 5'd14 || D !== 32'h104) begin errors++; $display("FAIL burst_idle: got RW=%0b DA=%0d D=%h want 0/14/104", RW, DA, D); end
    step();
    checks++; if (rf[12] !== 32'h102 || rf[14] !== 32'h104) begin errors++; $display("FAIL burst_rf: got %h/%h want 102/104", rf[12], rf[14]); end
  endtask

  task automatic test_hold();
    bus.rd_valid = 1; bus.rd_sa = 5'd1; bus.rd_sb = 5'd2;
    step();
    bus.rd_valid = 0;
    step();
    bus.rd_valid = 1; bus.rd_sa = 5'd3; bus.rd_sb = 5'd4;
    for (int j = 0; j < 3; j++) begin
      bus.wb_valid = 1; bus.wb_addr = 5'd15; bus.wb_data = 32'hA0 + j;
      #1;
      checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL hold_rd_ready%0d: got %0b want 0", j, bus.rd_ready); end
      step();
      checks++;
      if (bus.op_valid !== 1'b1 || bus.op_a !== 32'd1 || bus.op_b !== 32'd2 || AA !== 5'd1) begin
        errors++; $display("FAIL hold_stable%0d: got v=%0b a=%h b=%h AA=%0d want 1/1/2/1", j, bus.op_valid, bus.op_a, bus.op_b, AA);
      end
      if (j > 0) begin
        checks++;
        if (RW !== 1'b1 || DA !== 5'd15 || D !== 32'hA0 + j - 1) begin
          errors++; $display("FAIL hold_drain%0d: got RW=%0b DA=%0d D=%h want 1/15/%h", j, RW, DA, D, 32'hA0 + j - 1);
        end
      end
    end
    bus.wb_valid = 0;
    bus.op_ready = 1;
    #1;
    checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL hold_same_cycle_ready: got %0b want 1", bus.rd_ready); end
    step();
    bus.rd_valid = 0; bus.op_ready = 0;
    checks++; if (AA !== 5'd3 || BA !== 5'd4 || bus.op_valid !== 1'b0) begin errors++; $display("FAIL hold_reaccept: got AA=%0d BA=%0d v=%0b want 3/4/0", AA, BA, bus.op_valid); end
    checks++; if (RW !== 1'b1 || D !== 32'hA2) begin errors++; $display("FAIL hold_last_drain: got RW=%0b D=%h want 1/a2", RW, D); end
    step();
    checks++; if (bus.op_valid !== 1'b1 || bus.op_a !== 32'd3 || bus.op_b !== 32'd4) begin errors++; $display("FAIL hold_second_ops: got v=%0b %h/%h want 1/3/4", bus.op_valid, bus.op_a, bus.op_b); end
    bus.op_ready = 1;
    step();
    bus.op_ready = 0;
  endtask

  task automatic test_reset_mid();
    step(); step(); step();
    bus.rd_valid = 1; bus.rd_sa = 5'd3; bus.rd_sb = 5'd7;
    bus.wb_valid = 1; bus.wb_addr = 5'd25; bus.wb_data = 32'hC0DE_0025;
    step();
    bus.rd_valid = 0;
    bus.wb_addr = 5'd26; bus.wb_data = 32'hC0DE_0026;
    step();
    bus.wb_addr = 5'd27; bus.wb_data = 32'hC0DE_0027;
    step();
    bus.wb_valid = 0;
    checks++; if (RW !== 1'b1 || DA !== 5'd26 || bus.op_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got RW=%0b DA=%0d v=%0b want 1/26/1", RW, DA, bus.op_valid); end
    rst = 1'b1;
    #1;
    checks++; if (RW !== 1'b0) begin errors++; $display("FAIL rstmid_RW: got %0b want 0", RW); end
    checks++; if (bus.op_valid !== 1'b0 || bus.op_a !== 32'h0) begin errors++; $display("FAIL rstmid_op: got v=%0b a=%h want 0/0", bus.op_valid, bus.op_a); end
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (RW !== 1'b0 || bus.wb_ready !== 1'b1) begin errors++; $display("FAIL rstmid_empty%0d: got RW=%0b wb_ready=%0b want 0/1", k, RW, bus.wb_ready); end
    end
    checks++; if (rf[25] !== 32'hC0DE_0025) begin errors++; $display("FAIL rstmid_r25: got %h want c0de0025", rf[25]); end
    checks++; if (rf[26] !== 32'd26 || rf[27] !== 32'd27) begin errors++; $display("FAIL rstmid_r26_27: got %h/%h want 1a/1b", rf[26], rf[27]); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_then_read();
    test_youngest();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
